// File: rtl/axi4_stream_len_hdr_inserter_if.sv
// AXI4-Stream bundle shared by the length-header inserter and its neighbours.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TID_WIDTH   = 1
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic                     tlast;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TID_WIDTH-1:0]     tid;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
        output tready
    );
endinterface

// File: rtl/axi4_stream_len_hdr_inserter.sv
// Prepends a {magic, byte length} header to each complete packet from the FIFO
// and flags packets whose forwarded byte count disagrees with the advertised size.
module axi4_stream_len_hdr_inserter #(
    parameter int          TDATA_WIDTH    = 32,
    parameter int          TUSER_WIDTH    = 1,
    parameter int          TDEST_WIDTH    = 1,
    parameter int          TID_WIDTH      = 1,
    parameter int          PKT_SIZE_WIDTH = 5,
    parameter logic [15:0] HDR_MAGIC      = 16'hA55A
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [PKT_SIZE_WIDTH:0] pkt_size_i,
    axi4_stream_if.slave            pkt_i,
    axi4_stream_if.master           pkt_o,
    output logic                    len_err_o,
    output logic [15:0]             pkts_sent_o
);
    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam int CNT_W  = PKT_SIZE_WIDTH + 2;
    localparam logic [CNT_W-1:0] BYTES_PER_WORD = CNT_W'(TDATA_WIDTH / 8);

    typedef enum logic [0:0] {S_IDLE, S_PAYLOAD} state_e;

    state_e                   state_q, state_d;
    logic                     out_vld_q, out_vld_d;
    logic [TDATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [KEEP_W-1:0]        out_keep_q, out_keep_d;
    logic [KEEP_W-1:0]        out_strb_q, out_strb_d;
    logic                     out_last_q, out_last_d;
    logic [TUSER_WIDTH-1:0]   out_user_q, out_user_d;
    logic [TDEST_WIDTH-1:0]   out_dest_q, out_dest_d;
    logic [TID_WIDTH-1:0]     out_id_q, out_id_d;
    logic [PKT_SIZE_WIDTH:0]  exp_size_q, exp_size_d;
    logic [CNT_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic                     len_err_q, len_err_d;
    logic [15:0]              pkts_sent_q, pkts_sent_d;

    logic                     slot_free;
    logic                     in_ready;
    logic [CNT_W-1:0]         last_bytes;
    logic [TDATA_WIDTH-1:0]   hdr_data;

    // Valid/ready: a beat transfers on a rising clk_i edge where tvalid && tready;
    // once tvalid rises on pkt_o its fields hold until that transfer occurs.
    assign slot_free = !out_vld_q || pkt_o.tready;

    always_comb begin
        last_bytes = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (pkt_i.tkeep[i]) last_bytes = CNT_W'(i + 1);
        end
    end

    always_comb begin
        hdr_data = '0;
        hdr_data[TDATA_WIDTH-1 -: 16]  = HDR_MAGIC;
        hdr_data[PKT_SIZE_WIDTH:0]     = pkt_size_i;
    end

    always_comb begin
        state_d     = state_q;
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_strb_d  = out_strb_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        out_dest_d  = out_dest_q;
        out_id_d    = out_id_q;
        exp_size_d  = exp_size_q;
        byte_cnt_d  = byte_cnt_q;
        len_err_d   = 1'b0;
        pkts_sent_d = pkts_sent_q;
        in_ready    = 1'b0;

        if (out_vld_q && pkt_o.tready) begin
            out_vld_d = 1'b0;
            if (out_last_q) pkts_sent_d = pkts_sent_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                // The head word is only inspected here; it is consumed in PAYLOAD.
                if (pkt_i.tvalid && slot_free) begin
                    out_vld_d  = 1'b1;
                    out_data_d = hdr_data;
                    out_keep_d = '1;
                    out_strb_d = '1;
                    out_last_d = 1'b0;
                    out_user_d = pkt_i.tuser;
                    out_dest_d = pkt_i.tdest;
                    out_id_d   = pkt_i.tid;
                    exp_size_d = pkt_size_i;
                    byte_cnt_d = '0;
                    state_d    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                in_ready = slot_free;
                if (pkt_i.tvalid && slot_free) begin
                    out_vld_d  = 1'b1;
                    out_data_d = pkt_i.tdata;
                    out_keep_d = pkt_i.tkeep;
                    out_strb_d = pkt_i.tstrb;
                    out_last_d = pkt_i.tlast;
                    out_user_d = pkt_i.tuser;
                    out_dest_d = pkt_i.tdest;
                    out_id_d   = pkt_i.tid;
                    if (pkt_i.tlast) begin
                        len_err_d = ({1'b0, exp_size_q} != (byte_cnt_q + last_bytes));
                        state_d   = S_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTES_PER_WORD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= '0;
            out_dest_q  <= '0;
            out_id_q    <= '0;
            exp_size_q  <= '0;
            byte_cnt_q  <= '0;
            len_err_q   <= 1'b0;
            pkts_sent_q <= '0;
        end else begin
            state_q     <= state_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_strb_q  <= out_strb_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            out_dest_q  <= out_dest_d;
            out_id_q    <= out_id_d;
            exp_size_q  <= exp_size_d;
            byte_cnt_q  <= byte_cnt_d;
            len_err_q   <= len_err_d;
            pkts_sent_q <= pkts_sent_d;
        end
    end

    assign pkt_i.tready = in_ready;
    assign pkt_o.tvalid = out_vld_q;
    assign pkt_o.tdata  = out_data_q;
    assign pkt_o.tkeep  = out_keep_q;
    assign pkt_o.tstrb  = out_strb_q;
    assign pkt_o.tlast  = out_last_q;
    assign pkt_o.tuser  = out_user_q;
    assign pkt_o.tdest  = out_dest_q;
    assign pkt_o.tid    = out_id_q;
    assign len_err_o    = len_err_q;
    assign pkts_sent_o  = pkts_sent_q;
endmodule

// File: tb/tb_axi4_stream_len_hdr_inserter.sv
// Directed bench for the length-header inserter: header format, length check,
// back-to-back throughput, random backpressure and mid-packet reset.
module tb_axi4_stream_len_hdr_inserter;
    localparam int DW     = 32;
    localparam int KW     = DW / 8;
    localparam int PSW    = 5;
    localparam int BEAT_W = DW + 2 * KW + 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [PSW:0]   pkt_size = '0;
    logic           len_err;
    logic [15:0]    pkts_sent;

    axi4_stream_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1)) in_if ();
    axi4_stream_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1)) out_if ();

    axi4_stream_len_hdr_inserter #(
        .TDATA_WIDTH(DW), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1),
        .PKT_SIZE_WIDTH(PSW), .HDR_MAGIC(16'hA55A)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pkt_size_i(pkt_size),
        .pkt_i(in_if), .pkt_o(out_if),
        .len_err_o(len_err), .pkts_sent_o(pkts_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [BEAT_W-1:0] exp_q[$];
    logic [BEAT_W-1:0] got_q[$];
    int err_pulses = 0;
    int err_cyc = -1;
    int last_acc_cyc = -1;
    int vld_cnt = 0;
    int first_vld = -1;
    int last_vld = -1;
    bit rand_ready = 1'b0;
    bit prev_stall = 1'b0;
    logic [BEAT_W-1:0] prev_beat = '0;

    function automatic logic [BEAT_W-1:0] pack(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                               input logic [KW-1:0] s, input logic u, input logic ds,
                                               input logic id, input logic l);
        return {l, id, ds, u, s, k, d};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_if.tready = ($urandom_range(0, 1) == 1);
    end

    always @(negedge clk) begin
        logic [BEAT_W-1:0] cur;
        cur = pack(out_if.tdata, out_if.tkeep, out_if.tstrb, out_if.tuser, out_if.tdest,
                   out_if.tid, out_if.tlast);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks = checks + 1;
                if (!(out_if.tvalid === 1'b1 && cur === prev_beat)) begin
                    errors = errors + 1;
                    $display("FAIL stall_hold: got valid=%0b beat=%h, required valid=1 beat=%h",
                             out_if.tvalid, cur, prev_beat);
                end
            end
            prev_stall = out_if.tvalid && !out_if.tready;
            prev_beat  = cur;
            if (out_if.tvalid && out_if.tready) got_q.push_back(cur);
            if (in_if.tvalid && in_if.tready && in_if.tlast) last_acc_cyc = cyc;
            if (len_err) begin
                err_pulses = err_pulses + 1;
                err_cyc    = cyc;
            end
            if (out_if.tvalid) begin
                vld_cnt = vld_cnt + 1;
                if (first_vld < 0) first_vld = cyc;
                last_vld = cyc;
            end
        end
    end

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        err_pulses = 0;
        err_cyc = -1;
        last_acc_cyc = -1;
        vld_cnt = 0;
        first_vld = -1;
        last_vld = -1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_if.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Presents one packet the way the FIFO does: each word held until accepted.
    task automatic send_pkt(input int n, input logic [KW-1:0] lkeep, input logic [PSW:0] size);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic u, ds, id, hs;
        int guard;
        ds = 1'($urandom_range(0, 1));
        id = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            u = 1'($urandom_range(0, 1));
            k = (i == n - 1) ? lkeep : '1;
            if (i == 0) exp_q.push_back(pack({16'hA55A, 10'd0, size}, '1, '1, u, ds, id, 1'b0));
            exp_q.push_back(pack(d, k, k, u, ds, id, (i == n - 1)));
            in_if.tvalid = 1'b1;
            in_if.tdata  = d;
            in_if.tkeep  = k;
            in_if.tstrb  = k;
            in_if.tlast  = (i == n - 1);
            in_if.tuser  = u;
            in_if.tdest  = ds;
            in_if.tid    = id;
            pkt_size     = size;
            hs = 1'b0;
            guard = 0;
            while (!hs) begin
                @(negedge clk);
                hs = in_if.tready;
                @(posedge clk); #1;
                guard = guard + 1;
                if (!hs && guard > 200) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL send_timeout: got no tready in %0d cycles, required handshake", guard);
                    in_if.tvalid = 1'b0;
                    return;
                end
            end
        end
        in_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((got_q.size() < exp_q.size() || out_if.tvalid) && g < 2000) begin
            @(posedge clk);
            g = g + 1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tkeep = '0; in_if.tstrb = '0;
        in_if.tlast = 1'b0; in_if.tuser = '0; in_if.tdest = '0; in_if.tid = '0;
        out_if.tready = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks = checks + 5;
        if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, required 0", out_if.tvalid); end
        if (out_if.tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h, required 0", out_if.tdata); end
        if (len_err !== 1'b0) begin errors++; $display("FAIL rst_len_err: got %b, required 0", len_err); end
        if (pkts_sent !== 16'd0) begin errors++; $display("FAIL rst_pkts_sent: got %0d, required 0", pkts_sent); end
        if (in_if.tready !== 1'b0) begin errors++; $display("FAIL rst_in_tready: got %b, required 0", in_if.tready); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks = checks + 1;
        if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL idle_tvalid: got %b, required 0", out_if.tvalid); end
    endtask

    task automatic test_basic();
        logic [BEAT_W-1:0] b;
        clear_sb();
        send_pkt(3, 4'h3, 6'd10);
        wait_drain();
        checks = checks + 1;
        if (got_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d beats, required 4", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks = checks + 1;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() == 4) begin
            b = got_q[0];
            checks = checks + 1;
            if (b[DW-1:0] !== 32'hA55A000A) begin errors++; $display("FAIL basic_hdr: got %h, required a55a000a", b[DW-1:0]); end
            b = got_q[3];
            checks = checks + 1;
            if (b[BEAT_W-1] !== 1'b1) begin errors++; $display("FAIL basic_tlast: got %b, required 1", b[BEAT_W-1]); end
        end
        checks = checks + 2;
        if (err_pulses != 0) begin errors++; $display("FAIL basic_len_err: got %0d pulses, required 0", err_pulses); end
        if (pkts_sent !== 16'd1) begin errors++; $display("FAIL basic_pkts_sent: got %0d, required 1", pkts_sent); end
    endtask

    task automatic test_len_err();
        logic [BEAT_W-1:0] b;
        clear_sb();
        send_pkt(3, 4'h3, 6'd12);
        wait_drain();
        checks = checks + 1;
        if (got_q.size() != 4) begin errors++; $display("FAIL lenerr_count: got %0d beats, required 4", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks = checks + 1;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL lenerr_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() > 0) begin
            b = got_q[0];
            checks = checks + 1;
            if (b[DW-1:0] !== 32'hA55A000C) begin errors++; $display("FAIL lenerr_hdr: got %h, required a55a000c", b[DW-1:0]); end
        end
        checks = checks + 3;
        if (err_pulses != 1) begin errors++; $display("FAIL lenerr_pulses: got %0d, required 1", err_pulses); end
        if (err_cyc != last_acc_cyc + 1) begin errors++; $display("FAIL lenerr_timing: got cycle %0d, required %0d", err_cyc, last_acc_cyc + 1); end
        if (pkts_sent !== 16'd2) begin errors++; $display("FAIL lenerr_pkts_sent: got %0d, required 2", pkts_sent); end
    endtask

    task automatic test_one_word();
        logic [BEAT_W-1:0] b;
        clear_sb();
        send_pkt(1, 4'h1, 6'd1);
        wait_drain();
        checks = checks + 1;
        if (got_q.size() != 2) begin errors++; $display("FAIL one_count: got %0d beats, required 2", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks = checks + 1;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL one_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() == 2) begin
            b = got_q[0];
            checks = checks + 1;
            if (b[DW-1:0] !== 32'hA55A0001) begin errors++; $display("FAIL one_hdr: got %h, required a55a0001", b[DW-1:0]); end
        end
        checks = checks + 2;
        if (err_pulses != 0) begin errors++; $display("FAIL one_len_err: got %0d pulses, required 0", err_pulses); end
        if (pkts_sent !== 16'd3) begin errors++; $display("FAIL one_pkts_sent: got %0d, required 3", pkts_sent); end
    endtask

    task automatic test_back_to_back();
        logic [BEAT_W-1:0] b;
        clear_sb();
        send_pkt(4, 4'hF, 6'd16);
        send_pkt(4, 4'hF, 6'd16);
        wait_drain();
        checks = checks + 3;
        if (got_q.size() != 10) begin errors++; $display("FAIL b2b_count: got %0d beats, required 10", got_q.size()); end
        if (vld_cnt != 10) begin errors++; $display("FAIL b2b_valid_cycles: got %0d, required 10", vld_cnt); end
        if (last_vld - first_vld + 1 != 10) begin errors++; $display("FAIL b2b_span: got %0d cycles, required 10", last_vld - first_vld + 1); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks = checks + 1;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() == 10) begin
            b = got_q[5];
            checks = checks + 1;
            if (b[DW-1:0] !== 32'hA55A0010) begin errors++; $display("FAIL b2b_hdr2: got %h, required a55a0010", b[DW-1:0]); end
        end
        checks = checks + 2;
        if (err_pulses != 0) begin errors++; $display("FAIL b2b_len_err: got %0d pulses, required 0", err_pulses); end
        if (pkts_sent !== 16'd5) begin errors++; $display("FAIL b2b_pkts_sent: got %0d, required 5", pkts_sent); end
    endtask

    task automatic test_zero_keep();
        clear_sb();
        send_pkt(2, 4'h0, 6'd4);
        wait_drain();
        checks = checks + 3;
        if (got_q.size() != 3) begin errors++; $display("FAIL zkeep_count: got %0d beats, required 3", got_q.size()); end
        if (err_pulses != 0) begin errors++; $display("FAIL zkeep_len_err: got %0d pulses, required 0", err_pulses); end
        if (pkts_sent !== 16'd6) begin errors++; $display("FAIL zkeep_pkts_sent: got %0d, required 6", pkts_sent); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks = checks + 1;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL zkeep_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int n, hb;
        logic [KW-1:0] lk;
        do_reset();
        clear_sb();
        rand_ready = 1'b1;
        for (int p = 0; p < 200; p++) begin
            n  = $urandom_range(1, 6);
            lk = KW'($urandom_range(1, 15));
            hb = 0;
            for (int j = 0; j < KW; j++) if (lk[j]) hb = j + 1;
            send_pkt(n, lk, 6'((n - 1) * KW + hb));
        end
        wait_drain();
        rand_ready = 1'b0;
        out_if.tready = 1'b1;
        checks = checks + 3;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
        if (err_pulses != 0) begin errors++; $display("FAIL rand_len_err: got %0d pulses, required 0", err_pulses); end
        if (pkts_sent !== 16'd200) begin errors++; $display("FAIL rand_pkts_sent: got %0d, required 200", pkts_sent); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks = checks + 1;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [BEAT_W-1:0] b;
        clear_sb();
        out_if.tready = 1'b1;
        in_if.tvalid = 1'b1; in_if.tdata = 32'h1111_1111; in_if.tkeep = '1; in_if.tstrb = '1;
        in_if.tlast = 1'b0; pkt_size = 6'd12;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_if.tdata = 32'h2222_2222;
        #2 rst = 1'b1;
        in_if.tvalid = 1'b0;
        #1;
        checks = checks + 3;
        if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b, required 0", out_if.tvalid); end
        if (pkts_sent !== 16'd0) begin errors++; $display("FAIL rstmid_pkts_sent: got %0d, required 0", pkts_sent); end
        if (in_if.tready !== 1'b0) begin errors++; $display("FAIL rstmid_in_tready: got %b, required 0", in_if.tready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        clear_sb();
        send_pkt(1, 4'h1, 6'd1);
        wait_drain();
        checks = checks + 1;
        if (got_q.size() != 2) begin errors++; $display("FAIL rstmid_count: got %0d beats, required 2", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks = checks + 1;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() > 0) begin
            b = got_q[0];
            checks = checks + 1;
            if (b[DW-1:0] !== 32'hA55A0001) begin errors++; $display("FAIL rstmid_hdr: got %h, required a55a0001", b[DW-1:0]); end
        end
        checks = checks + 2;
        if (pkts_sent !== 16'd1) begin errors++; $display("FAIL rstmid_pkts_after: got %0d, required 1", pkts_sent); end
        if (err_pulses != 0) begin errors++; $display("FAIL rstmid_len_err: got %0d pulses, required 0", err_pulses); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_err();
        test_one_word();
        test_back_to_back();
        test_zero_keep();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
